button_debouncer: RTL and testbench



---
 rtl/button_pkg.sv | 28 ++
 rtl/button_debounce_channel.sv | 124 ++++++++++++
 rtl/button_debouncer.sv | 59 +++++
 tb/tb_button_debouncer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared helpers for the push-button debouncer: width function and raw-pin encodings.
// The BTN_HOLD_EN macro enables the per-channel auto-repeat (hold) logic.
package button_pkg;

  // 10 ms of stability at 50 MHz
  localparam int unsigned DefaultDebounceCycles = 500_000;

  localparam logic RawReleasedActiveLow  = 1'b1;
  localparam logic RawReleasedActiveHigh = 1'b0;

  // Minimum of 1 so a counter declared with this width is never zero-width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic released_level(input bit active_low);
    return active_low ? RawReleasedActiveLow : RawReleasedActiveHigh;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: synchroniser, stability counter, accepted level and press/release pulses.
// With BTN_HOLD_EN defined it also produces the auto-repeat hold pulse.
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = DefaultDebounceCycles,
  parameter bit          ActiveLow      = 1'b1
`ifdef BTN_HOLD_EN
  ,
  parameter int unsigned HoldCycles     = 25_000_000,
  parameter int unsigned RepeatCycles   = 5_000_000
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
`ifdef BTN_HOLD_EN
  ,
  output logic hold_o
`endif
);

  localparam int unsigned CntW     = clog2(DebounceCycles);
  localparam logic        Released = released_level(ActiveLow);

  logic [SyncStages-1:0] sync_q;
  logic                  sync_s;
  logic                  stable_q, stable_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  press_q, press_d;
  logic                  release_q, release_d;
  logic                  accept;

  assign sync_s = sync_q[SyncStages-1];
  assign accept = (sync_s != stable_q) && (cnt_q == CntW'(DebounceCycles - 1));

  // The counter only advances while below DebounceCycles-1, so it cannot wrap.
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync_s == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      stable_d  = sync_s;
      cnt_d     = '0;
      press_d   = (sync_s != Released);
      release_d = (sync_s == Released);
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= {SyncStages{Released}};
      stable_q  <= Released;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SyncStages-2:0], raw_i};
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = stable_q ^ ActiveLow;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_HOLD_EN
  localparam int unsigned HoldMax = (HoldCycles > RepeatCycles) ? HoldCycles : RepeatCycles;
  localparam int unsigned HoldW   = clog2(HoldMax);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             first_q, first_d;
  logic             hold_q, hold_d;
  logic             hold_fire;

  // first_q selects the initial hold delay; afterwards the shorter repeat interval applies.
  assign hold_fire = first_q ? (hold_cnt_q == HoldW'(HoldCycles - 1))
                             : (hold_cnt_q == HoldW'(RepeatCycles - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    first_d    = first_q;
    hold_d     = 1'b0;
    // Accept covers both the press edge (restart) and a release that suppresses a due pulse.
    if (!level_o || accept) begin
      hold_cnt_d = '0;
      first_d    = 1'b1;
    end else if (hold_fire) begin
      hold_cnt_d = '0;
      first_d    = 1'b0;
      hold_d     = 1'b1;
    end else begin
      hold_cnt_d = hold_cnt_q + HoldW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q <= '0;
      first_q    <= 1'b1;
      hold_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      first_q    <= first_d;
      hold_q     <= hold_d;
    end
  end

  assign hold_o = hold_q;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer feeding the PIO in_port with clean active-high levels.
// Define BTN_HOLD_EN to add the hold_pulse auto-repeat output.
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned HOLD_CYCLES     = 25_000_000,
  parameter int unsigned REPEAT_CYCLES   = 5_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
`ifdef BTN_HOLD_EN
  ,
  output logic [WIDTH-1:0] hold_pulse
`endif
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if ((HOLD_CYCLES < 1) || (REPEAT_CYCLES < 1)) begin : g_chk_hold
    $error("HOLD_CYCLES and REPEAT_CYCLES must be non-zero");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_debounce_channel #(
      .SyncStages    (SYNC_STAGES),
      .DebounceCycles(DEBOUNCE_CYCLES),
      .ActiveLow     (ACTIVE_LOW != 0)
`ifdef BTN_HOLD_EN
      ,
      .HoldCycles    (HOLD_CYCLES),
      .RepeatCycles  (REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .raw_i    (raw_in[i]),
      .level_o  (btn_level[i]),
      .press_o  (press_pulse[i]),
      .release_o(release_pulse[i])
`ifdef BTN_HOLD_EN
      ,
      .hold_o   (hold_pulse[i])
`endif
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer; hold checks are active when BTN_HOLD_EN is defined.
module tb_button_debouncer;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  hold;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] raw_in;
  logic [3:0] btn_level, press_pulse, release_pulse, hold_obs;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [3:0]  exp_lvl = 4'b0000;
  ev_t         sb[$];

  button_debouncer #(
    .WIDTH          (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW     (1),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (6)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
`ifdef BTN_HOLD_EN
    ,
    .hold_pulse   (hold_obs)
`endif
  );

`ifndef BTN_HOLD_EN
  assign hold_obs = 4'b0000;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected events are tagged with the posedge count after which they must be visible.
  task automatic test_reset();
    ev_t ev;
    logic [3:0] ep, er, eh;
    for (int k = 0; k < 55; k++) begin
      @(negedge clk);
      ep = '0; er = '0; eh = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ev = sb.pop_front(); ep = ev.press; er = ev.rel; eh = ev.hold;
      end
      exp_lvl = (exp_lvl | ep) & ~er;
      n_cmp++;
      if ({btn_level, press_pulse, release_pulse, hold_obs} !== {exp_lvl, ep, er, eh}) begin
        n_err++;
        $display("FAIL reset cyc=%0d got lvl/p/r/h=%b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 btn_level, press_pulse, release_pulse, hold_obs, exp_lvl, ep, er, eh);
      end
      if (k == 4) reset_n = 1'b1;
    end
  endtask

  task automatic test_clean_press();
    ev_t ev;
    logic [3:0] ep, er, eh;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      ep = '0; er = '0; eh = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ev = sb.pop_front(); ep = ev.press; er = ev.rel; eh = ev.hold;
      end
      exp_lvl = (exp_lvl | ep) & ~er;
      n_cmp++;
      if ({btn_level, press_pulse, release_pulse, hold_obs} !== {exp_lvl, ep, er, eh}) begin
        n_err++;
        $display("FAIL clean_press cyc=%0d got lvl/p/r/h=%b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 btn_level, press_pulse, release_pulse, hold_obs, exp_lvl, ep, er, eh);
      end
      if (k == 0) begin
        raw_in[0] = 1'b0;
        sb.push_back('{cyc + 10, 4'b0001, 4'b0000, 4'b0000});
`ifdef BTN_HOLD_EN
        for (int j = 0; j < 4; j++) sb.push_back('{cyc + 30 + 6 * j, 4'b0, 4'b0, 4'b0001});
`endif
      end
    end
  endtask

  task automatic test_release_parallel();
    ev_t ev;
    logic [3:0] ep, er, eh;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      ep = '0; er = '0; eh = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ev = sb.pop_front(); ep = ev.press; er = ev.rel; eh = ev.hold;
      end
      exp_lvl = (exp_lvl | ep) & ~er;
      n_cmp++;
      if ({btn_level, press_pulse, release_pulse, hold_obs} !== {exp_lvl, ep, er, eh}) begin
        n_err++;
        $display("FAIL release_parallel cyc=%0d got lvl/p/r/h=%b/%b/%b/%b want %b/%b/%b/%b",
                 cyc, btn_level, press_pulse, release_pulse, hold_obs, exp_lvl, ep, er, eh);
      end
      if (k == 0) begin
        raw_in[0] = 1'b1;
        raw_in[2] = 1'b0;
        sb.push_back('{cyc + 10, 4'b0100, 4'b0001, 4'b0000});
      end else if (k == 10) begin
        raw_in[2] = 1'b1;
        sb.push_back('{cyc + 10, 4'b0000, 4'b0100, 4'b0000});
      end
    end
  endtask

  task automatic test_bounce();
    ev_t ev;
    logic [3:0] ep, er, eh;
    for (int k = 0; k < 43; k++) begin
      @(negedge clk);
      ep = '0; er = '0; eh = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ev = sb.pop_front(); ep = ev.press; er = ev.rel; eh = ev.hold;
      end
      exp_lvl = (exp_lvl | ep) & ~er;
      n_cmp++;
      if ({btn_level, press_pulse, release_pulse, hold_obs} !== {exp_lvl, ep, er, eh}) begin
        n_err++;
        $display("FAIL bounce cyc=%0d got lvl/p/r/h=%b/%b/%b/%b want %b/%b/%b/%b", cyc,
                 btn_level, press_pulse, release_pulse, hold_obs, exp_lvl, ep, er, eh);
      end
      if (k < 30 && (k % 3) == 0) begin
        raw_in[1] = ~raw_in[1];
      end else if (k == 30) begin
        raw_in[1] = 1'b0;
        sb.push_back('{cyc + 10, 4'b0010, 4'b0000, 4'b0000});
      end
    end
  endtask

  task automatic test_reset_mid_count();
    ev_t ev;
    logic [3:0] ep, er, eh;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      ep = '0; er = '0; eh = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ev = sb.pop_front(); ep = ev.press; er = ev.rel; eh = ev.hold;
      end
      exp_lvl = (exp_lvl | ep) & ~er;
      n_cmp++;
      if ({btn_level, press_pulse, release_pulse, hold_obs} !== {exp_lvl, ep, er, eh}) begin
        n_err++;
        $display("FAIL reset_mid_count cyc=%0d got lvl/p/r/h=%b/%b/%b/%b want %b/%b/%b/%b",
                 cyc, btn_level, press_pulse, release_pulse, hold_obs, exp_lvl, ep, er, eh);
      end
      if (k == 0) begin
        raw_in[3] = 1'b0;
      end else if (k == 7) begin
        reset_n = 1'b0;
        exp_lvl = 4'b0000;
      end else if (k == 9) begin
        reset_n = 1'b1;
        // ch1 and ch3 are still held low, so both re-qualify as fresh presses.
        sb.push_back('{cyc + 10, 4'b1010, 4'b0000, 4'b0000});
      end else if (k == 19) begin
        raw_in[1] = 1'b1;
        raw_in[3] = 1'b1;
        sb.push_back('{cyc + 10, 4'b0000, 4'b1010, 4'b0000});
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending events want 0", sb.size());
    end
  endtask

  initial begin
    reset_n = 1'b0;
    raw_in  = 4'b1111;
    test_reset();
    test_clean_press();
    test_release_parallel();
    test_bounce();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
